// File: rtl/trade_counter_bank_pkg.sv
// Shared constants and helpers for the trade counter bank.
package trade_counter_bank_pkg;

  localparam logic MODE_HALT = 1'b0;
  localparam logic MODE_WRAP = 1'b1;

  localparam int unsigned DEFAULT_LIMIT = 99;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/trade_counter_ch.sv
// Single trade counter channel: count, halt flag, event pulses and a per-cycle counted strobe.
module trade_counter_ch #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               slow_clk,
  input  logic               reset,
  input  logic               enable_count,
  input  logic               inc,
  input  logic               clr,
  input  logic [COUNT_W-1:0] limit,
  input  logic               wrap_mode,
  output logic [COUNT_W-1:0] count,
  output logic               halt,
  output logic               halt_pulse,
  output logic               wrap_pulse,
  output logic               counted
);
  import trade_counter_bank_pkg::*;

  logic [COUNT_W-1:0] count_q, count_d;
  logic               halt_q, halt_d;
  logic               halt_pulse_q, halt_pulse_d;
  logic               wrap_pulse_q, wrap_pulse_d;
  logic               accept;

  always_comb begin
    count_d      = count_q;
    halt_d       = halt_q;
    halt_pulse_d = 1'b0;
    wrap_pulse_d = 1'b0;
    counted      = 1'b0;
    accept       = inc & enable_count & ~halt_q;
    if (clr) begin
      count_d = '0;
      halt_d  = 1'b0;
    end else if (accept) begin
      // Equality compare only: a count above the limit rolls over silently.
      if (count_q != limit) begin
        count_d = count_q + COUNT_W'(1);
        counted = 1'b1;
      end else if (wrap_mode == MODE_WRAP) begin
        count_d      = '0;
        wrap_pulse_d = 1'b1;
        counted      = 1'b1;
      end else begin
        halt_d       = 1'b1;
        halt_pulse_d = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clk or negedge reset) begin
    if (!reset) begin
      count_q      <= '0;
      halt_q       <= 1'b0;
      halt_pulse_q <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      halt_q       <= halt_d;
      halt_pulse_q <= halt_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign count      = count_q;
  assign halt       = halt_q;
  assign halt_pulse = halt_pulse_q;
  assign wrap_pulse = wrap_pulse_q;

endmodule

// File: rtl/trade_counter_bank.sv
// Multi-channel trade counter bank with programmable limit and saturating aggregate total.
module trade_counter_bank #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned COUNT_W       = 8,
  parameter int unsigned TOTAL_W       = 12,
  parameter int unsigned DEFAULT_LIMIT = trade_counter_bank_pkg::DEFAULT_LIMIT
) (
  input  logic                      slow_clk,
  input  logic                      reset,
  input  logic                      enable_count,
  input  logic [NUM_CH-1:0]         inc,
  input  logic [NUM_CH-1:0]         clr_ch,
  input  logic                      clr_all,
  input  logic                      limit_wr,
  input  logic [COUNT_W-1:0]        limit_in,
  input  logic                      wrap_mode,
  output logic [NUM_CH*COUNT_W-1:0] trade_count,
  output logic [NUM_CH-1:0]         halt_signal,
  output logic                      any_halt,
  output logic                      all_halt,
  output logic [NUM_CH-1:0]         halt_pulse,
  output logic [NUM_CH-1:0]         wrap_pulse,
  output logic [TOTAL_W-1:0]        total_count
);
  import trade_counter_bank_pkg::*;

  localparam int unsigned PopW = clog2(NUM_CH + 1);

  logic [COUNT_W-1:0] limit_q, limit_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic [NUM_CH-1:0]  counted;
  logic [PopW-1:0]    pop;
  logic [TOTAL_W:0]   sum;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trade_counter_ch #(
      .COUNT_W (COUNT_W)
    ) u_ch (
      .slow_clk     (slow_clk),
      .reset        (reset),
      .enable_count (enable_count),
      .inc          (inc[i]),
      .clr          (clr_ch[i] | clr_all),
      .limit        (limit_q),
      .wrap_mode    (wrap_mode),
      .count        (trade_count[i*COUNT_W +: COUNT_W]),
      .halt         (halt_signal[i]),
      .halt_pulse   (halt_pulse[i]),
      .wrap_pulse   (wrap_pulse[i]),
      .counted      (counted[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + PopW'(counted[i]);
    end
  end

  // One spare bit catches overflow so the total can clamp instead of wrapping.
  assign sum = {1'b0, total_q} + (TOTAL_W + 1)'(pop);

  always_comb begin
    limit_d = limit_wr ? limit_in : limit_q;
    if (clr_all) begin
      total_d = '0;
    end else if (sum[TOTAL_W]) begin
      total_d = '1;
    end else begin
      total_d = sum[TOTAL_W-1:0];
    end
  end

  always_ff @(posedge slow_clk or negedge reset) begin
    if (!reset) begin
      limit_q <= COUNT_W'(DEFAULT_LIMIT);
      total_q <= '0;
    end else begin
      limit_q <= limit_d;
      total_q <= total_d;
    end
  end

  assign total_count = total_q;
  assign any_halt    = |halt_signal;
  assign all_halt    = &halt_signal;

endmodule

// File: tb/tb_trade_counter_bank.sv
// Randomised and directed bench for trade_counter_bank against a behavioural model.
module tb_trade_counter_bank;

  localparam int VW = 4 * 8 + 4 + 2 + 4 + 4 + 12;

  logic        slow_clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable_count, clr_all, limit_wr, wrap_mode;
  logic [3:0]  inc, clr_ch;
  logic [7:0]  limit_in;
  logic [31:0] trade_count;
  logic [3:0]  halt_signal, halt_pulse, wrap_pulse;
  logic        any_halt, all_halt;
  logic [11:0] total_count;

  // Second instance built with a narrow total for saturation.
  logic        s_en, s_clr_all, s_limit_wr, s_wrap;
  logic [3:0]  s_inc, s_clr_ch;
  logic [7:0]  s_limit_in;
  logic [31:0] s_trade_count;
  logic [3:0]  s_halt, s_halt_pulse, s_wrap_pulse;
  logic        s_any, s_all;
  logic [3:0]  s_total;

  int mcnt[4];
  bit mhalt[4], mhp[4], mwp[4];
  int mtot, mlimit;
  int n_cmp = 0, n_bad = 0;

  logic [VW-1:0] obs, exp_vec;

  always #5 slow_clk = ~slow_clk;

  trade_counter_bank dut (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .enable_count (enable_count),
    .inc          (inc),
    .clr_ch       (clr_ch),
    .clr_all      (clr_all),
    .limit_wr     (limit_wr),
    .limit_in     (limit_in),
    .wrap_mode    (wrap_mode),
    .trade_count  (trade_count),
    .halt_signal  (halt_signal),
    .any_halt     (any_halt),
    .all_halt     (all_halt),
    .halt_pulse   (halt_pulse),
    .wrap_pulse   (wrap_pulse),
    .total_count  (total_count)
  );

  trade_counter_bank #(.TOTAL_W(4)) dut_sat (
    .slow_clk     (slow_clk),
    .reset        (reset),
    .enable_count (s_en),
    .inc          (s_inc),
    .clr_ch       (s_clr_ch),
    .clr_all      (s_clr_all),
    .limit_wr     (s_limit_wr),
    .limit_in     (s_limit_in),
    .wrap_mode    (s_wrap),
    .trade_count  (s_trade_count),
    .halt_signal  (s_halt),
    .any_halt     (s_any),
    .all_halt     (s_all),
    .halt_pulse   (s_halt_pulse),
    .wrap_pulse   (s_wrap_pulse),
    .total_count  (s_total)
  );

  assign obs = {trade_count, halt_signal, any_halt, all_halt, halt_pulse, wrap_pulse, total_count};

  task automatic build_exp();
    logic [31:0] tc;
    logic [3:0]  h, hp, wp;
    tc = '0; h = '0; hp = '0; wp = '0;
    for (int i = 0; i < 4; i++) begin
      tc[i*8 +: 8] = 8'(mcnt[i]);
      h[i] = mhalt[i]; hp[i] = mhp[i]; wp[i] = mwp[i];
    end
    exp_vec = {tc, h, |h, &h, hp, wp, 12'(mtot)};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0; mhalt[i] = 0; mhp[i] = 0; mwp[i] = 0;
    end
    mtot = 0;
    mlimit = 99;
    build_exp();
  endtask

  task automatic idle();
    enable_count = 1'b1; inc = '0; clr_ch = '0; clr_all = 1'b0;
    limit_wr = 1'b0; limit_in = '0;
  endtask

  // Apply one cycle of the current inputs to the model, then clock the DUT.
  task automatic step();
    int add;
    add = 0;
    for (int i = 0; i < 4; i++) begin
      mhp[i] = 0; mwp[i] = 0;
      if (clr_all || clr_ch[i]) begin
        mcnt[i] = 0; mhalt[i] = 0;
      end else if (inc[i] && enable_count && !mhalt[i]) begin
        if (mcnt[i] == mlimit) begin
          if (wrap_mode) begin mcnt[i] = 0; mwp[i] = 1; add++; end
          else begin mhalt[i] = 1; mhp[i] = 1; end
        end else begin
          mcnt[i] = (mcnt[i] + 1) % 256;
          add++;
        end
      end
    end
    if (clr_all) mtot = 0;
    else mtot = (mtot + add > 4095) ? 4095 : mtot + add;
    if (limit_wr) mlimit = int'(limit_in);
    @(posedge slow_clk);
    #1;
    build_exp();
  endtask

  task automatic test_reset();
    idle();
    wrap_mode = 1'b0;
    s_en = 1'b1; s_inc = '0; s_clr_ch = '0; s_clr_all = 1'b0;
    s_limit_wr = 1'b0; s_limit_in = '0; s_wrap = 1'b0;
    #12;
    n_cmp++;
    if (obs !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h expected 0", obs);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_halt_default();
    int pulses;
    pulses = 0;
    idle(); wrap_mode = 1'b0; inc = 4'b0001;
    for (int k = 0; k < 105; k++) begin
      step();
      pulses += int'(halt_pulse[0]);
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++; $display("FAIL halt_default cyc %0d: got %h expected %h", k, obs, exp_vec);
      end
    end
    n_cmp++;
    if (trade_count !== 32'd99 || halt_signal !== 4'b0001 || total_count !== 12'd99 || pulses != 1)
    begin
      n_bad++;
      $display("FAIL halt_final: got cnt=%h halt=%b tot=%0d pulses=%0d expected 99/0001/99/1",
               trade_count, halt_signal, total_count, pulses);
    end
  endtask

  task automatic test_wrap();
    int seq[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    idle(); wrap_mode = 1'b1; clr_all = 1'b1; limit_wr = 1'b1; limit_in = 8'd3;
    step();
    idle(); inc = 4'b0010;
    for (int k = 0; k < 9; k++) begin
      step();
      n_cmp++;
      if (trade_count[15:8] !== 8'(seq[k]) || wrap_pulse[1] !== (k == 3 || k == 7)) begin
        n_bad++;
        $display("FAIL wrap_seq %0d: got cnt=%0d wp=%b expected cnt=%0d wp=%b",
                 k, trade_count[15:8], wrap_pulse[1], seq[k], (k == 3 || k == 7));
      end
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++; $display("FAIL wrap_model %0d: got %h expected %h", k, obs, exp_vec);
      end
    end
    n_cmp++;
    if (total_count !== 12'd9) begin
      n_bad++; $display("FAIL wrap_total: got %0d expected 9", total_count);
    end
  endtask

  task automatic test_all_channels();
    idle(); wrap_mode = 1'b0; clr_all = 1'b1; limit_wr = 1'b1; limit_in = 8'd99;
    step();
    idle(); inc = 4'b1111;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (trade_count !== {4{8'd10}} || total_count !== 12'd40) begin
      n_bad++; $display("FAIL all_ch: got %h tot=%0d expected 0a0a0a0a tot=40", trade_count, total_count);
    end
    idle(); clr_ch = 4'b0100;
    step();
    n_cmp++;
    if (trade_count !== 32'h0a000a0a || total_count !== 12'd40 || obs !== exp_vec) begin
      n_bad++; $display("FAIL clr_ch2: got %h tot=%0d expected 0a000a0a tot=40", trade_count, total_count);
    end
  endtask

  task automatic test_clear_priority();
    idle(); wrap_mode = 1'b0; clr_all = 1'b1; limit_wr = 1'b1; limit_in = 8'd2;
    step();
    idle(); inc = 4'b0001;
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if (halt_signal[0] !== 1'b1 || trade_count[7:0] !== 8'd2) begin
      n_bad++; $display("FAIL prio_halted: got halt=%b cnt=%0d expected 1/2", halt_signal[0], trade_count[7:0]);
    end
    clr_ch = 4'b0001;
    step();
    n_cmp++;
    if (halt_signal[0] !== 1'b0 || trade_count[7:0] !== 8'd0 || total_count !== 12'd2) begin
      n_bad++;
      $display("FAIL prio_clear: got halt=%b cnt=%0d tot=%0d expected 0/0/2",
               halt_signal[0], trade_count[7:0], total_count);
    end
    clr_ch = '0;
    step();
    n_cmp++;
    if (trade_count[7:0] !== 8'd1 || obs !== exp_vec) begin
      n_bad++; $display("FAIL prio_next: got cnt=%0d expected 1", trade_count[7:0]);
    end
  endtask

  task automatic test_limit_below();
    idle(); wrap_mode = 1'b0; clr_all = 1'b1; limit_wr = 1'b1; limit_in = 8'd99;
    step();
    idle(); inc = 4'b0001;
    for (int k = 0; k < 10; k++) step();
    idle(); limit_wr = 1'b1; limit_in = 8'd5;
    step();
    idle(); inc = 4'b0001;
    for (int k = 0; k < 260 && !halt_signal[0]; k++) begin
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++; $display("FAIL limit_below cyc %0d: got %h expected %h", k, obs, exp_vec);
      end
    end
    n_cmp++;
    if (halt_signal[0] !== 1'b1 || trade_count[7:0] !== 8'd5) begin
      n_bad++; $display("FAIL limit_rollover: got halt=%b cnt=%0d expected 1/5", halt_signal[0], trade_count[7:0]);
    end
  endtask

  task automatic test_random();
    idle(); clr_all = 1'b1;
    step();
    for (int k = 0; k < 1500; k++) begin
      enable_count = ($urandom_range(0, 9) != 0);
      inc = 4'($urandom);
      clr_ch = ($urandom_range(0, 14) == 0) ? 4'($urandom) : 4'b0;
      clr_all = ($urandom_range(0, 99) == 0);
      limit_wr = ($urandom_range(0, 39) == 0);
      limit_in = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 29) == 0) wrap_mode = ~wrap_mode;
      step();
      n_cmp++;
      if (obs !== exp_vec) begin
        n_bad++; $display("FAIL random cyc %0d: got %h expected %h", k, obs, exp_vec);
      end
    end
  endtask

  task automatic test_saturation();
    idle();
    s_inc = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      step();
      n_cmp++;
      if (s_total !== 4'((k > 15) ? 15 : k)) begin
        n_bad++; $display("FAIL sat_total %0d: got %0d expected %0d", k, s_total, (k > 15) ? 15 : k);
      end
    end
    s_inc = '0;
    step();
    n_cmp++;
    if (s_total !== 4'd15 || s_trade_count[7:0] !== 8'd20) begin
      n_bad++; $display("FAIL sat_hold: got tot=%0d cnt=%0d expected 15/20", s_total, s_trade_count[7:0]);
    end
  endtask

  task automatic test_async_reset();
    idle(); wrap_mode = 1'b0; clr_all = 1'b1; limit_wr = 1'b1; limit_in = 8'd99;
    step();
    idle(); inc = 4'b0001;
    for (int k = 0; k < 57; k++) step();
    idle(); limit_wr = 1'b1; limit_in = 8'd0;
    step();
    idle(); inc = 4'b1000;
    step();
    idle();
    n_cmp++;
    if (trade_count[7:0] !== 8'd57 || halt_signal !== 4'b1000 || obs !== exp_vec) begin
      n_bad++; $display("FAIL pre_reset: got %h expected %h", obs, exp_vec);
    end
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== '0 || s_total !== '0) begin
      n_bad++; $display("FAIL async_reset: got %h expected 0", obs);
    end
    #2 reset = 1'b1;
    model_reset();
    inc = 4'b0001;
    for (int k = 0; k < 101; k++) step();
    n_cmp++;
    if (trade_count[7:0] !== 8'd99 || halt_signal !== 4'b0001 || obs !== exp_vec) begin
      n_bad++;
      $display("FAIL limit_restored: got cnt=%0d halt=%b expected 99/0001", trade_count[7:0], halt_signal);
    end
  endtask

  initial begin
    test_reset();
    test_halt_default();
    test_wrap();
    test_all_channels();
    test_clear_priority();
    test_limit_below();
    test_random();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/trade_counter_bank.md
Name: trade_counter_bank

Overview:
Parametrised multi-channel trade counter for the matching engine. Each channel (e.g. per symbol or per book side) counts accepted match events up to a runtime-programmable limit. At the limit the channel either halts or wraps, selected by a mode input. Also keeps a saturating aggregate trade total and produces halt status and event pulses for the VGA analytics path and the engine control FSM.

Parameters:
NUM_CH, 4, number of independent counter channels (1..16)
COUNT_W, 8, per-channel count width in bits
TOTAL_W, 12, aggregate total width; must be >= COUNT_W + clog2(NUM_CH)
DEFAULT_LIMIT, 99, limit value loaded at reset

Ports:
slow_clk  in  1  single clock for the whole block; all state updates on its rising edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
enable_count  in  1  global count enable; gates all increments
inc  in  NUM_CH  per-channel increment request, one per cycle max per channel
clr_ch  in  NUM_CH  per-channel synchronous clear (count and halt)
clr_all  in  1  synchronous clear of every channel plus the aggregate total
limit_wr  in  1  load limit_in into the limit register
limit_in  in  COUNT_W  new terminal count value
wrap_mode  in  1  0 = halt at limit, 1 = wrap to 0 at limit
trade_count  out  NUM_CH*COUNT_W  packed per-channel counts; channel i at bits [i*COUNT_W +: COUNT_W]
halt_signal  out  NUM_CH  per-channel halt flags
any_halt  out  1  OR of halt_signal
all_halt  out  1  AND of halt_signal
halt_pulse  out  NUM_CH  one-cycle pulse in the cycle after a channel's halt flag sets
wrap_pulse  out  NUM_CH  one-cycle pulse in the cycle after a channel wraps
total_count  out  TOTAL_W  saturating count of all accepted increments

Behaviour:
- Reset (reset=0, asynchronous): all trade_count=0, halt_signal=0, pulses=0, total_count=0, limit register=DEFAULT_LIMIT. Release is synchronous to slow_clk through the normal flop path.
- All outputs are registered. any_halt and all_halt derive from registered halt_signal with no added latency.
- Accept condition for channel i: inc[i] & enable_count & !halt_signal[i] & !clr_ch[i] & !clr_all.
- On accept:
  - If count_i != limit: count_i <= count_i+1.
  - If count_i == limit and wrap_mode=0: count_i holds, halt_i <= 1, halt_pulse[i]=1 next cycle. The request that hits the limit is not counted in the total.
  - If count_i == limit and wrap_mode=1: count_i <= 0, wrap_pulse[i]=1 next cycle. This request is counted in the total.
- Halted channel ignores inc until cleared. Changing wrap_mode does not release a halt.
- Clear priority per channel: clr_all > clr_ch[i] > increment. A clear in the same cycle as inc drops the increment. Clear zeroes count_i and halt_i and suppresses that channel's pulses.
- Limit:
  - limit_wr updates the limit register at the clock edge; the new value applies from the next cycle.
  - Comparison is equality only. If a count already exceeds the new limit, it continues incrementing and wraps naturally at 2^COUNT_W-1 -> 0; at that rollover no halt or wrap pulse is raised.
  - limit=0 with wrap_mode=0: the first accepted inc halts the channel with count 0.
- total_count:
  - Each cycle adds the popcount of increments counted that cycle (0..NUM_CH).
  - Saturates at 2^TOTAL_W-1 with no wrap.
  - Cleared only by clr_all or reset; clr_ch does not affect it. clr_all in the same cycle as increments yields 0.
- Pulses deassert automatically after one cycle.

Decomposition:
- Shared package: mode encoding constants (MODE_HALT=0, MODE_WRAP=1), DEFAULT_LIMIT, and a clog2 function.
- Natural sub-module: trade_counter_ch, a single-channel counter holding count, halt, and pulse logic plus an "accepted/counted" output. Instantiate NUM_CH times with generate.
- The top holds the limit register, the popcount adder, total saturation, and the any/all reductions.

Test Plan:
- Halt mode, defaults: 105 consecutive inc[0] -> trade_count[0] reaches 99, halt_signal[0]=1 with a single halt_pulse[0] cycle, count stays 99, total_count=99, other channels remain 0.
- Wrap mode, limit_wr with 3: 9 inc[1] -> counts 1,2,3,0,1,2,3,0,1; wrap_pulse[1] after the 4th and 8th accepted inc; total_count=9.
- All four channels inc together for 10 cycles -> each count=10, total_count=40. A clr_ch[2] pulse then zeroes only channel 2; total stays 40.
- Channel 0 halted, then clr_ch[0] and inc[0] in the same cycle -> count 0, halt 0, no increment. Next inc -> count 1.
- TOTAL_W=4 build, 20 accepted incs -> total_count saturates at 15.
- reset driven low mid-count (count=57, halt set on channel 3) asynchronously between edges -> all outputs 0 immediately, limit back to 99.
